// File: rtl/a51_pkg.sv
// a51_pkg: shared A5/1 constants (register geometry, taps, clock bits, burst sizing) and FSM state type.
// The ST_UP state is only present when A51_UPLINK_EN is defined.
package a51_pkg;

  localparam int MIXCYCLES = 100;
  localparam int BURSTLEN  = 114;
  localparam int CNT_W     = 8;

  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_FRAME = 3'd2,
    ST_MIX   = 3'd3,
    ST_DOWN  = 3'd4,
`ifdef A51_UPLINK_EN
    ST_UP    = 3'd5,
`endif
    ST_DONE  = 3'd6
  } state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a51_lfsr.sv
// a51_lfsr: one A5/1 shift register; shifts left with tap-parity (plus load_bit) into bit 0.
// msb reports the top bit the register will hold after this cycle, so keystream can be registered same-cycle.
module a51_lfsr #(
  parameter int            LEN     = 19,
  parameter logic [LEN-1:0] TAPS   = '0,
  parameter int            CLK_POS = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic load_bit,
  input  logic force_clk,
  input  logic maj_clk,
  output logic msb,
  output logic clk_bit
);

  logic [LEN-1:0] reg_q;
  logic [LEN-1:0] reg_d;
  logic           shift_s;

  // Next register contents: clear, shift with feedback, or hold.
  always_comb begin
    shift_s = force_clk | maj_clk;
    if (clear) begin
      reg_d = '0;
    end else if (shift_s) begin
      reg_d = {reg_q[LEN-2:0], (^(reg_q & TAPS)) ^ load_bit};
    end else begin
      reg_d = reg_q;
    end
  end

  // Register state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign msb     = shift_s ? reg_q[LEN-2] : reg_q[LEN-1];
  assign clk_bit = reg_q[CLK_POS];

endmodule

// File: rtl/a51_burst_cipher.sv
// a51_burst_cipher: A5/1 key/frame load, 100-cycle majority mix, then XOR of a serial burst with keystream.
// Define A51_UPLINK_EN to append a 114-bit uplink half (dir=1) after the downlink half.
module a51_burst_cipher
  import a51_pkg::*;
#(
  parameter int KEYLEN      = 64,
  parameter int FRAMENUMLEN = 22
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KEYLEN-1:0]      key,
  input  logic [FRAMENUMLEN-1:0] frame,
  output logic                   busy,
  input  logic                   in_valid,
  input  logic                   in_bit,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic                   out_bit,
  output logic                   dir,
  output logic                   done
);

  localparam int KEY_IW = $clog2(KEYLEN);
  localparam int FR_IW  = $clog2(FRAMENUMLEN);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [KEYLEN-1:0]      key_q, key_d;
  logic [FRAMENUMLEN-1:0] frame_q, frame_d;

  logic busy_q, busy_d;
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic out_bit_q, out_bit_d;
  logic dir_q, dir_d;
  logic done_q, done_d;

  logic accept_s, stream_s, step_s, maj_s;
  logic clear_s, force_s, load_s;
  logic c1_s, c2_s, c3_s, m1_s, m2_s, m3_s;
  logic mclk1_s, mclk2_s, mclk3_s;

  assign accept_s = in_valid & in_ready_q;

  // State, counter and latched key/frame registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      frame_q <= frame_d;
    end
  end

  // Next-state and phase counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    frame_d = frame_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key;
          frame_d = frame;
          cnt_d   = '0;
          state_d = ST_KEY;
        end else begin
          cnt_d = '0;
        end
      end
      ST_KEY: begin
        if (cnt_q == CNT_W'(KEYLEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_FRAME;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FRAME: begin
        if (cnt_q == CNT_W'(FRAMENUMLEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_MIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_MIX: begin
        if (cnt_q == CNT_W'(MIXCYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_DOWN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DOWN: begin
        if (accept_s && (cnt_q == CNT_W'(BURSTLEN - 1))) begin
          cnt_d = '0;
`ifdef A51_UPLINK_EN
          state_d = ST_UP;
`else
          state_d = ST_DONE;
`endif
        end else if (accept_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
`ifdef A51_UPLINK_EN
      ST_UP: begin
        if (accept_s && (cnt_q == CNT_W'(BURSTLEN - 1))) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else if (accept_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Register clocking controls, keystream XOR and next output values.
  always_comb begin
    clear_s  = (state_q == ST_IDLE) && start;
    force_s  = (state_q == ST_KEY) || (state_q == ST_FRAME);
`ifdef A51_UPLINK_EN
    stream_s = (state_q == ST_DOWN) || (state_q == ST_UP);
`else
    stream_s = (state_q == ST_DOWN);
`endif
    if (state_q == ST_KEY) begin
      load_s = key_q[cnt_q[KEY_IW-1:0]];
    end else if (state_q == ST_FRAME) begin
      load_s = frame_q[cnt_q[FR_IW-1:0]];
    end else begin
      load_s = 1'b0;
    end
    step_s  = (state_q == ST_MIX) || (stream_s && accept_s);
    maj_s   = maj3(c1_s, c2_s, c3_s);
    mclk1_s = step_s && (c1_s == maj_s);
    mclk2_s = step_s && (c2_s == maj_s);
    mclk3_s = step_s && (c3_s == maj_s);

    out_valid_d = stream_s && accept_s;
    out_bit_d   = out_valid_d ? (in_bit ^ m1_s ^ m2_s ^ m3_s) : 1'b0;
`ifdef A51_UPLINK_EN
    dir_d      = out_valid_d && (state_q == ST_UP);
    in_ready_d = (state_d == ST_DOWN) || (state_d == ST_UP);
`else
    dir_d      = 1'b0;
    in_ready_d = (state_d == ST_DOWN);
`endif
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign dir       = dir_q;
  assign done      = done_q;

  a51_lfsr #(.LEN(R1_LEN), .TAPS(R1_TAPS), .CLK_POS(R1_CLK)) u_r1 (
    .clock(clock), .reset(reset), .clear(clear_s), .load_bit(load_s),
    .force_clk(force_s), .maj_clk(mclk1_s), .msb(m1_s), .clk_bit(c1_s)
  );

  a51_lfsr #(.LEN(R2_LEN), .TAPS(R2_TAPS), .CLK_POS(R2_CLK)) u_r2 (
    .clock(clock), .reset(reset), .clear(clear_s), .load_bit(load_s),
    .force_clk(force_s), .maj_clk(mclk2_s), .msb(m2_s), .clk_bit(c2_s)
  );

  a51_lfsr #(.LEN(R3_LEN), .TAPS(R3_TAPS), .CLK_POS(R3_CLK)) u_r3 (
    .clock(clock), .reset(reset), .clear(clear_s), .load_bit(load_s),
    .force_clk(force_s), .maj_clk(mclk3_s), .msb(m3_s), .clk_bit(c3_s)
  );

endmodule

// File: tb/tb_a51_burst_cipher.sv
// tb_a51_burst_cipher: randomized self-checking bench against an integer-level A5/1 model.
// Honours A51_UPLINK_EN (228-bit bursts with dir=1 on the second half).
`timescale 1ns/1ps
module tb_a51_burst_cipher;

`ifdef A51_UPLINK_EN
  localparam int NB = 228;
`else
  localparam int NB = 114;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] key   = 64'd0;
  logic [21:0] frame = 22'd0;
  logic        in_valid = 1'b0;
  logic        in_bit   = 1'b0;
  logic        busy, in_ready, out_valid, out_bit, dir, done;

  typedef struct {
    int   due;
    logic b;
    logic d;
    int   idx;
  } exp_t;

  exp_t exp_q[$];
  logic ks[0:227];
  logic src_bits[0:227];
  logic cap_bits[0:227];
  logic pt_bits[0:227];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   last_out_cyc = 0;

  localparam logic [63:0] STD_KEY   = 64'hEFCDAB8967452312;
  localparam logic [21:0] STD_FRAME = 22'h134;
  logic [119:0] dl_hex;
  logic [119:0] ul_hex;

  a51_burst_cipher dut (
    .clock(clock), .reset(reset), .start(start), .key(key), .frame(frame),
    .busy(busy), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_bit(out_bit), .dir(dir), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] v, input logic [31:0] mask,
                                       input logic [31:0] taps);
    return ((v << 1) & mask) | {31'd0, ^(v & taps)};
  endfunction

  // Integer-level A5/1: keystream for 228 bits after load and 100 discarded mix steps.
  task automatic gen_ks(input logic [63:0] k, input logic [21:0] f);
    logic [31:0] r1, r2, r3;
    logic b, m, c1, c2, c3;
    r1 = 32'd0; r2 = 32'd0; r3 = 32'd0;
    for (int i = 0; i < 86; i++) begin
      if (i < 64) b = k[i];
      else        b = f[i-64];
      r1 = step(r1, 32'h7FFFF, 32'h72000)  ^ {31'd0, b};
      r2 = step(r2, 32'h3FFFFF, 32'h300000) ^ {31'd0, b};
      r3 = step(r3, 32'h7FFFFF, 32'h700080) ^ {31'd0, b};
    end
    for (int i = 0; i < 100 + 228; i++) begin
      c1 = r1[8]; c2 = r2[10]; c3 = r3[10];
      m = (c1 & c2) | (c1 & c3) | (c2 & c3);
      if (c1 == m) r1 = step(r1, 32'h7FFFF, 32'h72000);
      if (c2 == m) r2 = step(r2, 32'h3FFFFF, 32'h300000);
      if (c3 == m) r3 = step(r3, 32'h7FFFFF, 32'h700080);
      if (i >= 100) ks[i-100] = r1[18] ^ r2[21] ^ r3[22];
    end
  endtask

  // Output compare: every cycle, out_valid must match the predicted schedule exactly.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          chk("out_valid", int'(out_valid), 1);
          chk("out_bit", int'(out_bit), int'(e.b));
          chk("dir", int'(dir), int'(e.d));
          cap_bits[e.idx] = out_bit;
          last_out_cyc = cyc;
        end else begin
          chk("idle_out_valid", int'(out_valid), 0);
        end
        if (done) done_cnt++;
      end
    end
  endtask

  function automatic int vec_errs(input logic [119:0] dh, input logic [119:0] uh, input int src);
    int errs;
    logic got;
    errs = 0;
    for (int i = 0; i < NB; i++) begin
      got = (src == 0) ? ks[i] : cap_bits[i];
      if (i < 114) begin
        if (got !== dh[119-i]) errs++;
      end else begin
        if (got !== uh[119-(i-114)]) errs++;
      end
    end
    return errs;
  endfunction

  task automatic run_burst(input logic [63:0] k, input logic [21:0] f, input int duty,
                           input int busy_start_at);
    int c0, ka, ca, fa, t;
    exp_t e;
    gen_ks(k, f);
    exp_q.delete();
    done_cnt = 0;
    ca = 0; fa = 0;
    @(posedge clock); #1;
    chk("idle_busy", int'(busy), 0);
    key = k; frame = f; start = 1'b1; c0 = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    key = {$urandom, $urandom};
    frame = 22'($urandom);
    chk("busy_after_start", int'(busy), 1);
    t = 0;
    while (!in_ready && t < 400) begin
      in_valid = 1'($urandom_range(1, 0));
      in_bit   = 1'($urandom_range(1, 0));
      @(posedge clock); #1;
      t++;
    end
    chk("start_to_ready", cyc - (c0 + 1), 186);
    ka = 0; t = 0;
    while (ka < NB && t < 4000) begin
      in_valid = ($urandom_range(99, 0) < duty);
      in_bit   = src_bits[ka];
      if (busy_start_at == ka) begin
        start = 1'b1;
        key   = ~k;
      end else begin
        start = 1'b0;
      end
      if (in_valid && in_ready) begin
        e.due = cyc + 1; e.b = src_bits[ka] ^ ks[ka]; e.d = (ka >= 114); e.idx = ka;
        exp_q.push_back(e);
        if (ka == 0) fa = cyc;
        ca = cyc;
        ka++;
      end
      @(posedge clock); #1;
      t++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk("bits_accepted", ka, NB);
    if (duty >= 100) chk("full_rate_span", ca - fa, NB - 1);
    chk("ready_drop", int'(in_ready), 0);
    chk("busy_before_done", int'(busy), 1);
    t = 0;
    while (!done && t < 10) begin
      @(posedge clock); #1;
      t++;
    end
    chk("done_seen", int'(done), 1);
    chk("done_after_last_out", cyc, last_out_cyc + 1);
    chk("busy_falls_with_done", int'(busy), 0);
    repeat (3) @(posedge clock);
    #1;
    chk("done_count", done_cnt, 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dl_hex = 120'h534EAA582FE8151AB6E1855A728C00;
    ul_hex = 120'h24FD35A35D5FB6526D32F906DF1AC0;
    fork
      monitor();
    join_none

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bit", int'(out_bit), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clock);
    reset = 1'b1;

    // Pin the model to the published vector (first byte 0x53 by hand, then all bits).
    gen_ks(STD_KEY, STD_FRAME);
    chk("model_first_byte", int'({ks[0], ks[1], ks[2], ks[3], ks[4], ks[5], ks[6], ks[7]}), 8'h53);
    chk("model_std_vector", vec_errs(dl_hex, ul_hex, 0), 0);

    // Standard vector, full rate.
    for (int i = 0; i < 228; i++) src_bits[i] = 1'b0;
    run_burst(STD_KEY, STD_FRAME, 100, -1);
    chk("dut_std_full_rate", vec_errs(dl_hex, ul_hex, 1), 0);

    // Standard vector with 30% input duty.
    for (int i = 0; i < 228; i++) cap_bits[i] = 1'bx;
    run_burst(STD_KEY, STD_FRAME, 30, -1);
    chk("dut_std_stalled", vec_errs(dl_hex, ul_hex, 1), 0);

    // Round trip with a random key, frame and plaintext.
    begin
      logic [63:0] rk;
      logic [21:0] rf;
      int errs;
      rk = {$urandom, $urandom};
      rf = 22'($urandom);
      for (int i = 0; i < 228; i++) begin
        pt_bits[i]  = 1'($urandom_range(1, 0));
        src_bits[i] = pt_bits[i];
      end
      run_burst(rk, rf, 60, -1);
      for (int i = 0; i < 228; i++) src_bits[i] = cap_bits[i];
      run_burst(rk, rf, 100, -1);
      errs = 0;
      for (int i = 0; i < NB; i++) if (cap_bits[i] !== pt_bits[i]) errs++;
      chk("round_trip", errs, 0);
    end

    // Reset in the middle of the mix phase.
    @(posedge clock); #1;
    key = STD_KEY; frame = STD_FRAME; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (120) @(posedge clock);
    #2;
    chk("mix_busy_before_reset", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_in_ready", int'(in_ready), 0);
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_done", int'(done), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 228; i++) begin
      src_bits[i] = 1'b0;
      cap_bits[i] = 1'bx;
    end
    run_burst(STD_KEY, STD_FRAME, 100, -1);
    chk("dut_std_after_reset", vec_errs(dl_hex, ul_hex, 1), 0);

    // Start pulsed mid-stream with a different key must be ignored.
    for (int i = 0; i < 228; i++) cap_bits[i] = 1'bx;
    run_burst(STD_KEY, STD_FRAME, 100, 50);
    chk("dut_std_start_busy", vec_errs(dl_hex, ul_hex, 1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
